id_ex_operand_stage: RTL and testbench

- ID/EX pipeline register plus EX-side operand selection and forwarding for the 5-stage RV32I core.
- Captures decoded instruction fields from ID each cycle.
- Drives the ALU's ALUSel/inp1/inp2 from registered state, with forwarding from the EX/MEM and MEM/WB stages.
- Detects load-use hazards and requests an IF/ID stall.

---
 rtl/pipe_pkg.sv | 72 +++++++
 rtl/fwd_unit.sv | 25 ++
 rtl/id_ex_operand_stage.sv | 179 +++++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and helpers for the ID/EX operand stage
//
// Purpose : ALU op encoding, forwarding-source select, the packed ID/EX
//           pipeline record, datapath widths and the forwarding priority
//           helper used by fwd_unit.
// Ports   : none (package).
// Macro   : EX_FWD_EN is consumed by id_ex_operand_stage, not here.
package pipe_pkg;

   localparam int XLEN = 32;
   localparam int RAW  = 5;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_SLL   = 4'd2,
      ALU_SLT   = 4'd3,
      ALU_SLTU  = 4'd4,
      ALU_XOR   = 4'd5,
      ALU_SRL   = 4'd6,
      ALU_SRA   = 4'd7,
      ALU_OR    = 4'd8,
      ALU_AND   = 4'd9,
      ALU_LUI   = 4'd10,
      ALU_AUIPC = 4'd11
   } alusel_t;

   typedef enum logic [1:0] {
      FWD_RF    = 2'd0,
      FWD_EXMEM = 2'd1,
      FWD_MEMWB = 2'd2
   } fwd_sel_t;

   // Everything captured from ID on a normal load.
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [RAW-1:0]  rs1;
      logic [RAW-1:0]  rs2;
      logic [RAW-1:0]  rd;
      alusel_t         alusel;
      logic            op1_pc;
      logic            op2_imm;
      logic            reg_write;
      logic            mem_read;
      logic            mem_write;
   } id_ex_t;

   // The youngest producer (EX/MEM) wins; x0 is hard-wired zero and never
   // takes a forwarded value.
   function automatic fwd_sel_t fwd_pick(
      input logic [RAW-1:0] rs,
      input logic [RAW-1:0] exmem_rd,
      input logic           exmem_reg_write,
      input logic [RAW-1:0] memwb_rd,
      input logic           memwb_reg_write
   );
      fwd_sel_t sel;
      sel = FWD_RF;
      if (rs != '0) begin
         if (exmem_reg_write && (exmem_rd == rs)) begin
            sel = FWD_EXMEM;
         end else if (memwb_reg_write && (memwb_rd == rs)) begin
            sel = FWD_MEMWB;
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/fwd_unit.sv
// rtl/fwd_unit.sv - forwarding source selection for both EX operands
//
// Purpose : picks the source of rs1 and rs2 for the instruction in EX.
// Ports   : rs1, rs2                         registered source indices
//           exmem_rd, exmem_reg_write        EX/MEM write-back info
//           memwb_rd, memwb_reg_write        MEM/WB write-back info
//           rs1_sel, rs2_sel                 selected source per operand
// Macro   : only instantiated when EX_FWD_EN is defined.
module fwd_unit
   import pipe_pkg::*;
(
   input  logic [RAW-1:0] rs1,
   input  logic [RAW-1:0] rs2,
   input  logic [RAW-1:0] exmem_rd,
   input  logic           exmem_reg_write,
   input  logic [RAW-1:0] memwb_rd,
   input  logic           memwb_reg_write,
   output fwd_sel_t       rs1_sel,
   output fwd_sel_t       rs2_sel
);

   assign rs1_sel = fwd_pick(rs1, exmem_rd, exmem_reg_write, memwb_rd, memwb_reg_write);
   assign rs2_sel = fwd_pick(rs2, exmem_rd, exmem_reg_write, memwb_rd, memwb_reg_write);

endmodule

// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX register, EX operand muxing, hazard stall
//
// Purpose : registers the decoded instruction, drives the ALU operands with
//           forwarding from EX/MEM and MEM/WB, and raises load_use_stall
//           toward IF/ID.
// Ports   : clk, rst_n                       clock, async active-low reset
//           id_*                             decoded instruction from ID
//           flush, hold                      kill EX entry / freeze stage
//           exmem_*, memwb_*                 downstream write-back info
//           load_use_stall                   hold PC and IF/ID
//           ex_valid, ex_alusel, alu_inp1/2  ALU-facing outputs
//           ex_store_data, ex_pc, ex_rd      registered/forwarded fields
//           ex_reg_write/mem_read/mem_write  control, qualified by ex_valid
// Macro   : EX_FWD_EN - defined: operand forwarding, stall only on load-use.
//           undefined: no forwarding, stall on any RAW hazard against EX or
//           EX/MEM (register file write-before-read covers MEM/WB).
module id_ex_operand_stage #(
   parameter int XLEN = 32,
   parameter int RAW  = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            id_valid,
   input  logic [XLEN-1:0] id_pc,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic [XLEN-1:0] id_imm,
   input  logic [RAW-1:0]  id_rs1,
   input  logic [RAW-1:0]  id_rs2,
   input  logic [RAW-1:0]  id_rd,
   input  logic [3:0]      id_alusel,
   input  logic            id_op1_pc,
   input  logic            id_op2_imm,
   input  logic            id_reg_write,
   input  logic            id_mem_read,
   input  logic            id_mem_write,
   input  logic            flush,
   input  logic            hold,
   input  logic [RAW-1:0]  exmem_rd,
   input  logic            exmem_reg_write,
   input  logic [XLEN-1:0] exmem_result,
   input  logic [RAW-1:0]  memwb_rd,
   input  logic            memwb_reg_write,
   input  logic [XLEN-1:0] memwb_result,
   output logic            load_use_stall,
   output logic            ex_valid,
   output logic [3:0]      ex_alusel,
   output logic [XLEN-1:0] alu_inp1,
   output logic [XLEN-1:0] alu_inp2,
   output logic [XLEN-1:0] ex_store_data,
   output logic [XLEN-1:0] ex_pc,
   output logic [RAW-1:0]  ex_rd,
   output logic            ex_reg_write,
   output logic            ex_mem_read,
   output logic            ex_mem_write
);

   import pipe_pkg::*;

   id_ex_t          id_d;
   id_ex_t          ex_q;
   logic            ex_valid_q;
   logic [XLEN-1:0] fwd_rs1;
   logic [XLEN-1:0] fwd_rs2;

   // Control bits are qualified at capture so an invalid ID slot can never
   // produce a write in a later stage.
   always_comb begin
      id_d           = '0;
      id_d.pc        = id_pc;
      id_d.rs1_data  = id_rs1_data;
      id_d.rs2_data  = id_rs2_data;
      id_d.imm       = id_imm;
      id_d.rs1       = id_rs1;
      id_d.rs2       = id_rs2;
      id_d.rd        = id_rd;
      id_d.alusel    = alusel_t'(id_alusel);
      id_d.op1_pc    = id_op1_pc;
      id_d.op2_imm   = id_op2_imm;
      id_d.reg_write = id_reg_write & id_valid;
      id_d.mem_read  = id_mem_read  & id_valid;
      id_d.mem_write = id_mem_write & id_valid;
   end

   // Priority: flush, then hold, then bubble on stall, then normal load.
   // Flush and bubble only clear valid/control; data fields are don't-care
   // in those cases and are left alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid_q <= 1'b0;
         ex_q       <= '0;
      end else if (flush) begin
         ex_valid_q     <= 1'b0;
         ex_q.reg_write <= 1'b0;
         ex_q.mem_read  <= 1'b0;
         ex_q.mem_write <= 1'b0;
      end else if (!hold) begin
         if (load_use_stall) begin
            ex_valid_q     <= 1'b0;
            ex_q.reg_write <= 1'b0;
            ex_q.mem_read  <= 1'b0;
            ex_q.mem_write <= 1'b0;
         end else begin
            ex_valid_q <= id_valid;
            ex_q       <= id_d;
         end
      end
   end

`ifdef EX_FWD_EN
   fwd_sel_t rs1_sel;
   fwd_sel_t rs2_sel;

   fwd_unit u_fwd (
      .rs1             (ex_q.rs1),
      .rs2             (ex_q.rs2),
      .exmem_rd        (exmem_rd),
      .exmem_reg_write (exmem_reg_write),
      .memwb_rd        (memwb_rd),
      .memwb_reg_write (memwb_reg_write),
      .rs1_sel         (rs1_sel),
      .rs2_sel         (rs2_sel)
   );

   always_comb begin
      fwd_rs1 = ex_q.rs1_data;
      case (rs1_sel)
         FWD_EXMEM: fwd_rs1 = exmem_result;
         FWD_MEMWB: fwd_rs1 = memwb_result;
         default:   fwd_rs1 = ex_q.rs1_data;
      endcase
   end

   always_comb begin
      fwd_rs2 = ex_q.rs2_data;
      case (rs2_sel)
         FWD_EXMEM: fwd_rs2 = exmem_result;
         FWD_MEMWB: fwd_rs2 = memwb_result;
         default:   fwd_rs2 = ex_q.rs2_data;
      endcase
   end

   // Only a load in EX cannot be forwarded in time. rs2 is compared even
   // for I-type, which can cost a spurious one-cycle stall.
   assign load_use_stall = ex_valid_q & ex_q.mem_read & (ex_q.rd != '0) & id_valid
                         & ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2)) & ~flush;
`else
   logic hazard_ex;
   logic hazard_exmem;
   logic unused_fwd_inputs;

   assign fwd_rs1 = ex_q.rs1_data;
   assign fwd_rs2 = ex_q.rs2_data;

   // Without forwarding, any producer still in EX or EX/MEM blocks ID.
   assign hazard_ex    = ex_valid_q & ex_q.reg_write & (ex_q.rd != '0)
                       & ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2));
   assign hazard_exmem = exmem_reg_write & (exmem_rd != '0)
                       & ((exmem_rd == id_rs1) | (exmem_rd == id_rs2));

   assign load_use_stall = id_valid & ~flush & (hazard_ex | hazard_exmem);

   assign unused_fwd_inputs = ^{exmem_result, memwb_rd, memwb_reg_write,
                                memwb_result, ex_q.rs1, ex_q.rs2};
`endif

   assign alu_inp1      = ex_q.op1_pc  ? ex_q.pc  : fwd_rs1;
   assign alu_inp2      = ex_q.op2_imm ? ex_q.imm : fwd_rs2;
   assign ex_store_data = fwd_rs2;

   assign ex_valid     = ex_valid_q;
   assign ex_alusel    = ex_q.alusel;
   assign ex_pc        = ex_q.pc;
   assign ex_rd        = ex_q.rd;
   assign ex_reg_write = ex_valid_q & ex_q.reg_write;
   assign ex_mem_read  = ex_valid_q & ex_q.mem_read;
   assign ex_mem_write = ex_valid_q & ex_q.mem_write;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb/tb_id_ex_operand_stage.sv - scoreboard bench for id_ex_operand_stage
module tb_id_ex_operand_stage;

   localparam int S_VALID  = 0;
   localparam int S_ALUSEL = 1;
   localparam int S_INP1   = 2;
   localparam int S_INP2   = 3;
   localparam int S_STORE  = 4;
   localparam int S_STALL  = 5;
   localparam int S_PC     = 6;
   localparam int S_RD     = 7;
   localparam int S_RW     = 8;
   localparam int S_MR     = 9;
   localparam int S_MW     = 10;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid;
   logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [3:0]  id_alusel;
   logic        id_op1_pc, id_op2_imm, id_reg_write, id_mem_read, id_mem_write;
   logic        flush, hold;
   logic [4:0]  exmem_rd, memwb_rd;
   logic        exmem_reg_write, memwb_reg_write;
   logic [31:0] exmem_result, memwb_result;
   logic        load_use_stall, ex_valid;
   logic [3:0]  ex_alusel;
   logic [31:0] alu_inp1, alu_inp2, ex_store_data, ex_pc;
   logic [4:0]  ex_rd;
   logic        ex_reg_write, ex_mem_read, ex_mem_write;

   typedef struct {
      string       name;
      int          cyc;
      int          sig;
      logic [31:0] val;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   logic [31:0] act;
   int          cyc   = 0;
   int          total = 0;
   int          bad   = 0;

   id_ex_operand_stage #(.XLEN(32), .RAW(5)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alusel(id_alusel),
      .id_op1_pc(id_op1_pc), .id_op2_imm(id_op2_imm), .id_reg_write(id_reg_write),
      .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .flush(flush), .hold(hold),
      .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
      .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
      .load_use_stall(load_use_stall), .ex_valid(ex_valid), .ex_alusel(ex_alusel),
      .alu_inp1(alu_inp1), .alu_inp2(alu_inp2), .ex_store_data(ex_store_data),
      .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] actual(input int sig);
      case (sig)
         S_VALID:  return {31'b0, ex_valid};
         S_ALUSEL: return {28'b0, ex_alusel};
         S_INP1:   return alu_inp1;
         S_INP2:   return alu_inp2;
         S_STORE:  return ex_store_data;
         S_STALL:  return {31'b0, load_use_stall};
         S_PC:     return ex_pc;
         S_RD:     return {27'b0, ex_rd};
         S_RW:     return {31'b0, ex_reg_write};
         S_MR:     return {31'b0, ex_mem_read};
         S_MW:     return {31'b0, ex_mem_write};
         default:  return 32'hdead_beef;
      endcase
   endfunction

   // Monitor: compares every expectation tagged for the current cycle at the
   // falling edge, away from the capture edge.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         total++;
         act = actual(e.sig);
         if (e.cyc != cyc) begin
            bad++;
            $display("FAIL %s: expectation for cycle %0d not checked in time (now %0d)",
                     e.name, e.cyc, cyc);
         end else if (act !== e.val) begin
            bad++;
            $display("FAIL %s: cycle %0d got 0x%0h expected 0x%0h", e.name, cyc, act, e.val);
         end
      end
   end

   task automatic expect_sig(input string name, input int sig, input logic [31:0] val);
      exp_t x;
      x.name = name;
      x.cyc  = cyc;
      x.sig  = sig;
      x.val  = val;
      sb.push_back(x);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic id_set(input logic v, input logic [31:0] pc,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                         input logic [3:0] sel, input logic op1pc, input logic op2imm,
                         input logic rw, input logic mr, input logic mw);
      id_valid = v;    id_pc = pc;       id_rs1 = rs1;     id_rs2 = rs2;
      id_rd = rd;      id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
      id_alusel = sel; id_op1_pc = op1pc; id_op2_imm = op2imm;
      id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
   endtask

   task automatic id_clear();
      id_set(1'b0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic wb_set(input logic [4:0] erd, input logic ewe, input logic [31:0] eres,
                         input logic [4:0] mrd, input logic mwe, input logic [31:0] mres);
      exmem_rd = erd; exmem_reg_write = ewe; exmem_result = eres;
      memwb_rd = mrd; memwb_reg_write = mwe; memwb_result = mres;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; flush = 1'b0; hold = 1'b0;
      id_clear();
      wb_set(0, 0, 0, 0, 0, 0);

      // Reset values
      step();
      expect_sig("rst_valid",  S_VALID,  0);
      expect_sig("rst_alusel", S_ALUSEL, 0);
      expect_sig("rst_stall",  S_STALL,  0);
      expect_sig("rst_rw",     S_RW,     0);
      step();
      rst_n = 1'b1;

      // ADD x3,x1,x2 in flight, then async reset mid-stream
      id_set(1, 32'h40, 1, 2, 3, 32'h4, 32'h8, 0, 4'd0, 0, 0, 1, 0, 0);
      step();
      expect_sig("add_valid", S_VALID, 1);
      expect_sig("add_inp1",  S_INP1,  32'h4);
      expect_sig("add_inp2",  S_INP2,  32'h8);
      step();
      rst_n = 1'b0;
      #1;
      expect_sig("async_rst_valid", S_VALID, 0);
      expect_sig("async_rst_rw",    S_RW,    0);
      step();
      rst_n = 1'b1;
      expect_sig("post_rst_valid", S_VALID, 0);
      step();
      expect_sig("first_after_rst_valid", S_VALID, 1);
      expect_sig("first_after_rst_pc",    S_PC,    32'h40);

      // SUB x4,x3,x1 right behind ADD x3
      id_set(1, 32'h44, 3, 1, 4, 32'h99, 32'h4, 0, 4'd1, 0, 0, 1, 0, 0);
`ifdef EX_FWD_EN
      expect_sig("sub_no_stall", S_STALL, 0);
      step();
      wb_set(3, 1, 32'h10, 0, 0, 0);
      id_clear();
      expect_sig("sub_fwd_inp1", S_INP1,   32'h10);
      expect_sig("sub_inp2",     S_INP2,   32'h4);
      expect_sig("sub_alusel",   S_ALUSEL, 1);
      expect_sig("sub_store",    S_STORE,  32'h4);
`else
      expect_sig("sub_raw_stall_ex", S_STALL, 1);
      step();
      wb_set(3, 1, 32'h10, 0, 0, 0);
      expect_sig("sub_bubble1",         S_VALID, 0);
      expect_sig("sub_raw_stall_exmem", S_STALL, 1);
      step();
      wb_set(0, 0, 0, 0, 0, 0);
      id_rs1_data = 32'h10;
      expect_sig("sub_bubble2",   S_VALID, 0);
      expect_sig("sub_stall_off", S_STALL, 0);
      step();
      id_clear();
      expect_sig("sub_valid",  S_VALID,  1);
      expect_sig("sub_inp1",   S_INP1,   32'h10);
      expect_sig("sub_inp2",   S_INP2,   32'h4);
      expect_sig("sub_alusel", S_ALUSEL, 1);
`endif
      step();
      wb_set(0, 0, 0, 0, 0, 0);

      // Forwarding priority and x0
      id_set(1, 32'h50, 5, 0, 0, 32'h11, 32'h22, 0, 4'd0, 0, 0, 0, 0, 0);
      step();
      wb_set(5, 1, 32'hAA, 5, 1, 32'hBB);
`ifdef EX_FWD_EN
      expect_sig("prio_exmem_inp1", S_INP1, 32'hAA);
`else
      expect_sig("prio_rf_inp1", S_INP1, 32'h11);
`endif
      id_set(1, 32'h54, 0, 6, 0, 32'h33, 32'h44, 0, 4'd0, 0, 0, 0, 0, 0);
      step();
      wb_set(0, 1, 32'hAA, 6, 1, 32'hBB);
      id_clear();
      expect_sig("x0_rf_inp1", S_INP1, 32'h33);
`ifdef EX_FWD_EN
      expect_sig("memwb_inp2",  S_INP2,  32'hBB);
      expect_sig("memwb_store", S_STORE, 32'hBB);
`else
      expect_sig("rf_inp2",  S_INP2,  32'h44);
      expect_sig("rf_store", S_STORE, 32'h44);
`endif
      step();
      wb_set(0, 0, 0, 0, 0, 0);

      // LW x6 then ADD x7,x6,x6
      id_set(1, 32'h60, 1, 0, 6, 32'h1000, 0, 32'h8, 4'd0, 0, 1, 1, 1, 0);
      step();
      expect_sig("lw_mem_read", S_MR,   1);
      expect_sig("lw_rd",       S_RD,   6);
      expect_sig("lw_inp2_imm", S_INP2, 32'h8);
      id_set(1, 32'h64, 6, 6, 7, 0, 0, 0, 4'd0, 0, 0, 1, 0, 0);
      expect_sig("load_use_stall", S_STALL, 1);
      step();
      wb_set(6, 1, 32'h77, 0, 0, 0);
      expect_sig("lu_bubble_valid", S_VALID, 0);
      expect_sig("lu_bubble_mr",    S_MR,    0);
`ifdef EX_FWD_EN
      expect_sig("lu_stall_one_cycle", S_STALL, 0);
      step();
      wb_set(0, 0, 0, 6, 1, 32'h77);
`else
      expect_sig("lu_stall_exmem", S_STALL, 1);
      step();
      wb_set(0, 0, 0, 0, 0, 0);
      id_rs1_data = 32'h77;
      id_rs2_data = 32'h77;
      expect_sig("lu_stall_off", S_STALL, 0);
      step();
`endif
      id_clear();
      expect_sig("lu_add_valid", S_VALID, 1);
      expect_sig("lu_add_inp1",  S_INP1,  32'h77);
      expect_sig("lu_add_inp2",  S_INP2,  32'h77);
      step();
      wb_set(0, 0, 0, 0, 0, 0);

      // flush and hold together
      id_set(1, 32'h70, 0, 0, 9, 0, 0, 0, 4'd0, 0, 0, 1, 0, 0);
      flush = 1'b1;
      hold  = 1'b1;
      step();
      flush = 1'b0;
      hold  = 1'b0;
      expect_sig("flush_hold_valid", S_VALID, 0);
      expect_sig("flush_hold_rw",    S_RW,    0);

      // hold for 3 cycles
      id_set(1, 32'h200, 2, 0, 10, 32'h5, 0, 32'h7, 4'd2, 0, 1, 1, 0, 0);
      step();
      id_set(1, 32'h300, 1, 1, 11, 32'h9, 32'h9, 0, 4'd0, 0, 0, 1, 0, 0);
      hold = 1'b1;
      for (int i = 0; i < 4; i++) begin
         expect_sig("hold_valid",  S_VALID,  1);
         expect_sig("hold_pc",     S_PC,     32'h200);
         expect_sig("hold_inp1",   S_INP1,   32'h5);
         expect_sig("hold_inp2",   S_INP2,   32'h7);
         expect_sig("hold_alusel", S_ALUSEL, 2);
         if (i < 3) step();
      end
      hold = 1'b0;
      step();
      id_clear();
      expect_sig("after_hold_pc", S_PC, 32'h300);

      // AUIPC
      id_set(1, 32'h100, 0, 0, 1, 0, 0, 32'h1, 4'd11, 1, 1, 1, 0, 0);
      step();
      expect_sig("auipc_inp1",   S_INP1,   32'h100);
      expect_sig("auipc_inp2",   S_INP2,   32'h1);
      expect_sig("auipc_alusel", S_ALUSEL, 11);
      expect_sig("auipc_rd",     S_RD,     1);
      expect_sig("auipc_rw",     S_RW,     1);

      // Control qualified by id_valid
      id_set(0, 32'h104, 0, 0, 2, 0, 0, 0, 4'd0, 0, 0, 1, 0, 1);
      step();
      id_clear();
      expect_sig("inv_valid", S_VALID, 0);
      expect_sig("inv_rw",    S_RW,    0);
      expect_sig("inv_mw",    S_MW,    0);

      step();
      step();
      @(negedge clk);
      #1;
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
